// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, prescale width and parity types.
// Both the transmit and receive paths use this package.
package uart_pkg;

   localparam int PRESCALE_W = 5;

   typedef logic [2:0] uart_state_t;

   localparam uart_state_t IDLE   = 3'd0;
   localparam uart_state_t START  = 3'd1;
   localparam uart_state_t DATA   = 3'd2;
   localparam uart_state_t PARITY = 3'd3;
   localparam uart_state_t STOP   = 3'd4;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   // An odd-parity bit is the inverse of the XOR reduction of the data word.
   function automatic logic parity_bit(input logic typ, input logic data_xor);
      return (typ == PARITY_ODD) ? ~data_xor : data_xor;
   endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer for the UART transmitter: pulses bit_done on the last cycle of each bit.
// A prescale of 0 makes the 5-bit counter wrap at 31, giving 32 cycles per bit.
module uart_tx_bit_timer
   import uart_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  bit_done
);

   localparam logic [PRESCALE_W-1:0] ONE = 1;

   logic [PRESCALE_W-1:0] count;

   assign bit_done = run && (count == (prescale - ONE));

   // Holding the counter at zero while idle means every bit starts from a cleared count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (!run || bit_done) begin
         count <= '0;
      end else begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s); idle-high line.
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  TX_OUT,
   output logic                  busy
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = 1;

   uart_state_t           state;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic [PRESCALE_W-1:0] prescale_q;
   logic [CNT_W-1:0]      bit_cnt;
   logic [CNT_W-1:0]      next_idx;
   logic                  bit_done;
`ifdef UART_TX_TWO_STOP_EN
   logic                  stop_cnt;
`endif

   assign next_idx = bit_cnt + CNT_ONE;

   uart_tx_bit_timer u_bit_timer (
      .clk      (clk),
      .rst      (rst),
      .run      (state != IDLE),
      .prescale (prescale_q),
      .bit_done (bit_done)
   );

   // TX_OUT is loaded with the level of the bit being entered, so it changes with the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         prescale_q <= '0;
         bit_cnt    <= '0;
         TX_OUT     <= 1'b1;
         busy       <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
         stop_cnt   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (Data_Valid) begin
                  data_q     <= P_DATA;
                  par_en_q   <= PAR_EN;
                  par_typ_q  <= PAR_TYP;
                  prescale_q <= prescale;
                  state      <= START;
                  TX_OUT     <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            START: begin
               if (bit_done) begin
                  state   <= DATA;
                  bit_cnt <= '0;
                  TX_OUT  <= data_q[0];
               end
            end
            DATA: begin
               if (bit_done) begin
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
                     if (par_en_q) begin
                        state  <= PARITY;
                        TX_OUT <= parity_bit(par_typ_q, ^data_q);
                     end else begin
                        state  <= STOP;
                        TX_OUT <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= next_idx;
                     TX_OUT  <= data_q[next_idx];
                  end
               end
            end
            PARITY: begin
               if (bit_done) begin
                  state  <= STOP;
                  TX_OUT <= 1'b1;
               end
            end
            STOP: begin
               if (bit_done) begin
`ifdef UART_TX_TWO_STOP_EN
                  if (!stop_cnt) begin
                     stop_cnt <= 1'b1;
                  end else begin
                     stop_cnt <= 1'b0;
                     state    <= IDLE;
                     busy     <= 1'b0;
                  end
`else
                  state <= IDLE;
                  busy  <= 1'b0;
`endif
               end
            end
            default: begin
               state  <= IDLE;
               TX_OUT <= 1'b1;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx; frames are given as hand-built LSB-first bit vectors.
// Honours UART_TX_TWO_STOP_EN when the RTL is built with it.
module tb_uart_tx;

`ifdef UART_TX_TWO_STOP_EN
   localparam int STOP_BITS = 2;
`else
   localparam int STOP_BITS = 1;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [4:0] prescale;
   logic       TX_OUT;
   logic       busy;

   int total = 0;
   int bad   = 0;

   uart_tx #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .prescale   (prescale),
      .TX_OUT     (TX_OUT),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic obs, input logic exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] d, input logic pe, input logic pt,
                                input logic [4:0] ps, input logic dv);
      P_DATA     = d;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      prescale   = ps;
      Data_Valid = dv;
   endtask

   // mode 0: single request; 1: noisy request mid-frame; 2: Data_Valid left high past the end
   task automatic runFrame(input string tag, input logic [15:0] bits, input int nbits,
                           input logic [7:0] d, input logic pe, input logic pt,
                           input logic [4:0] ps, input int exp_busy, input int mode);
      int   p;
      int   busy_cnt;
      logic expv;
      p        = (ps == 5'd0) ? 32 : int'(ps);
      busy_cnt = 0;
      @(negedge clk);
      applyStimulus(d, pe, pt, ps, 1'b1);
      @(posedge clk);
      for (int b = 0; b < nbits + STOP_BITS; b++) begin
         for (int c = 0; c < p; c++) begin
            @(negedge clk);
            expv = (b < nbits) ? bits[b] : 1'b1;
            checkOutput($sformatf("%s tx bit%0d cyc%0d", tag, b, c), TX_OUT, expv);
            if (busy) busy_cnt++;
            if (mode != 2 && b == 0 && c == 0) Data_Valid = 1'b0;
            if (mode == 1 && b == 3 && c == 1) applyStimulus(8'h11, 1'b0, ~pt, 5'd2, 1'b1);
            if (mode == 1 && b == 3 && c == 2) Data_Valid = 1'b0;
         end
      end
      @(negedge clk);
      checkOutput({tag, " idle tx"}, TX_OUT, 1'b1);
      checkOutput({tag, " idle busy"}, busy, 1'b0);
      total = total + 1;
      assert (busy_cnt == exp_busy + (STOP_BITS - 1) * p) else begin
         bad = bad + 1;
         $error("FAIL %s busy_cycles observed=%0d expected=%0d", tag, busy_cnt,
                exp_busy + (STOP_BITS - 1) * p);
      end
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b0;
      applyStimulus(8'h00, 1'b0, 1'b0, 5'd0, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("reset tx", TX_OUT, 1'b1);
      checkOutput("reset busy", busy, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("post-reset tx", TX_OUT, 1'b1);
      checkOutput("post-reset busy", busy, 1'b0);

      // frame = {parity, data, start}, stop bits appended by runFrame
      runFrame("a5_even_p8", 16'({1'b0, 8'hA5, 1'b0}), 10, 8'hA5, 1'b1, 1'b0, 5'd8, 88, 0);
      runFrame("00_odd_p16", 16'({1'b1, 8'h00, 1'b0}), 10, 8'h00, 1'b1, 1'b1, 5'd16, 176, 0);
      runFrame("ff_even_p16", 16'({1'b0, 8'hFF, 1'b0}), 10, 8'hFF, 1'b1, 1'b0, 5'd16, 176, 0);
      runFrame("3c_nopar_p32", 16'({8'h3C, 1'b0}), 9, 8'h3C, 1'b0, 1'b0, 5'd0, 320, 0);
      runFrame("96_odd_glitch", 16'({1'b1, 8'h96, 1'b0}), 10, 8'h96, 1'b1, 1'b1, 5'd4, 44, 1);
      runFrame("81_even_hold", 16'({1'b0, 8'h81, 1'b0}), 10, 8'h81, 1'b1, 1'b0, 5'd4, 44, 2);

      @(negedge clk);
      checkOutput("back-to-back start tx", TX_OUT, 1'b0);
      checkOutput("back-to-back start busy", busy, 1'b1);
      Data_Valid = 1'b0;
      repeat (17) @(negedge clk);
      checkOutput("pre-reset data bit3 tx", TX_OUT, 1'b0);
      checkOutput("pre-reset data bit3 busy", busy, 1'b1);
      #2 rst = 1'b0;
      #1;
      checkOutput("mid-frame reset tx", TX_OUT, 1'b1);
      checkOutput("mid-frame reset busy", busy, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("after mid-frame reset tx", TX_OUT, 1'b1);
      checkOutput("after mid-frame reset busy", busy, 1'b0);

      runFrame("c3_nopar_p8", 16'({8'hC3, 1'b0}), 9, 8'hC3, 1'b0, 1'b0, 5'd8, 80, 0);
      runFrame("a5_nopar_p4", 16'({8'hA5, 1'b0}), 9, 8'hA5, 1'b0, 1'b0, 5'd4, 40, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that pairs with the UART receive path: accepts one parallel word per frame on a valid strobe and shifts it out LSB-first as start bit, DATA_WIDTH data bits, optional parity bit and stop bit(s). Each bit is held on the line for `prescale` clock cycles, matching the receiver's oversampling configuration, so TX and RX on the same `clk` and `prescale` interoperate directly. It is a peer of the receiver at the top of the serial interface and drives the line idle-high.

## Interface
- `DATA_WIDTH`, 8, parallel word width / data bits per frame
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `P_DATA`  in  DATA_WIDTH  word to transmit, sampled on acceptance
- `Data_Valid`  in  1  request strobe; accepted only in IDLE
- `PAR_EN`  in  1  1 = insert parity bit; sampled on acceptance
- `PAR_TYP`  in  1  0 = even, 1 = odd parity; sampled on acceptance
- `prescale`  in  5  clock cycles per bit; 0 means 32; sampled on acceptance
- `TX_OUT`  out  1  serial line, registered, idle high
- `busy`  out  1  registered, high while a frame is in progress

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: `TX_OUT`=1, `busy`=0. `Data_Valid`=1 → latch `P_DATA`, `PAR_EN`, `PAR_TYP`, `prescale`; go to START.
- `Data_Valid` outside IDLE is ignored (no queueing, no error).
- START: `TX_OUT`=0 for one bit time → DATA.
- DATA: bit i (i=0..DATA_WIDTH-1, LSB first) for one bit time each; after bit DATA_WIDTH-1 → PARITY if latched PAR_EN, else STOP.
- PARITY: `TX_OUT` = XOR(data) for even, ~XOR(data) for odd; computed from latched word.
- STOP: `TX_OUT`=1 for one bit time → IDLE.
- Bit timer: 5-bit edge counter, cleared on each bit entry; bit ends when counter = latched prescale−1 (prescale 0 → wraps at 31, i.e. 32 cycles).
- Bit counter: $clog2(DATA_WIDTH) bits, used only in DATA.
- Frame length in bits: 1 + DATA_WIDTH + PAR_EN + stop bits.
- Input changes mid-frame have no effect (all latched).

## Timing
- Reset (async, any time incl. mid-frame): `TX_OUT`=1, `busy`=0, state IDLE, counters 0, latched word 0.
- `Data_Valid` high at edge N in IDLE → `TX_OUT`=0 and `busy`=1 from edge N+1.
- Each bit occupies exactly P cycles (P = prescale, or 32 when 0); frame occupies bits×P cycles of `busy`=1.
- Last STOP cycle ends at edge M → `busy`=0, `TX_OUT`=1 from M; earliest next acceptance at edge M (`Data_Valid` high in that cycle), next start bit from M+1. Minimum inter-frame idle: 1 cycle.

## Configuration
- `UART_TX_TWO_STOP_EN` defined: STOP lasts two bit times (2P cycles); frame = 2 + DATA_WIDTH + PAR_EN + 1 bits.
- Undefined: one stop bit.

## Structure
- Shared package `uart_pkg`: state encoding typedef (IDLE..STOP), prescale width constant (5), parity-type constants EVEN=0/ODD=1; shared with RX.
- One sub-module: `uart_tx_bit_timer` (edge counter, prescale-0 handling, `bit_done` pulse). Parity is an inline XOR-reduce.

## Test plan
- 0xA5, PAR_EN=1, PAR_TYP=0, prescale=8 → line 0,1,0,1,0,0,1,0,1,0,1, each 8 cycles; `busy` high 88 cycles.
- 0x00, PAR_EN=1, PAR_TYP=1, prescale=16 → parity bit 1; 0xFF even → parity 0.
- 0x3C, PAR_EN=0, prescale=0 → 10 bits × 32 cycles = 320 busy cycles, no parity slot.
- `Data_Valid` pulsed mid-frame with 0x11 → ignored, frame unchanged; `Data_Valid` held through end → next frame starts after exactly 1 idle cycle.
- `rst` low during DATA bit 3 → `TX_OUT`=1, `busy`=0 immediately; next request sends full clean frame.
- With `UART_TX_TWO_STOP_EN`, 0xA5, PAR_EN=0, prescale=4 → stop high 8 cycles, `busy` 44 cycles.
